id_stage: RTL and testbench

Instruction-decode stage of the five-stage 32-bit pipelined CPU, sitting between IF and EX. It decodes the IF/ID instruction and reads two GPR operands with EX/MEM forwarding. It resolves branches and jumps in-stage and flags load-use hazards and decode-time exceptions. Results are registered into the ID/EX pipeline register.

---
 rtl/id_stage_pkg.sv | 45 ++++
 rtl/id_stage_if.sv | 22 ++
 rtl/id_stage_decoder.sv | 121 ++++++++++++
 rtl/id_stage.sv | 87 ++++++++
 tb/tb_id_stage.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/id_stage_pkg.sv
// Shared encodings and widths for the instruction-decode stage.
package id_stage_pkg;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 30;
    localparam int REG_W  = 5;

    localparam logic [5:0] OP_ANDR  = 6'h00, OP_ANDI  = 6'h01, OP_ORR   = 6'h02, OP_ORI   = 6'h03;
    localparam logic [5:0] OP_XORR  = 6'h04, OP_XORI  = 6'h05, OP_ADDSR = 6'h06, OP_ADDSI = 6'h07;
    localparam logic [5:0] OP_ADDUR = 6'h08, OP_ADDUI = 6'h09, OP_SUBSR = 6'h0A, OP_SUBUR = 6'h0B;
    localparam logic [5:0] OP_SHRLR = 6'h0C, OP_SHRLI = 6'h0D, OP_SHLLR = 6'h0E, OP_SHLLI = 6'h0F;
    localparam logic [5:0] OP_BE    = 6'h10, OP_BNE   = 6'h11, OP_BSGT  = 6'h12, OP_BUGT  = 6'h13;
    localparam logic [5:0] OP_JMP   = 6'h14, OP_CALL  = 6'h15, OP_LDW   = 6'h16, OP_STW   = 6'h17;
    localparam logic [5:0] OP_TRAP  = 6'h18, OP_RDCR  = 6'h19, OP_WRCR  = 6'h1A, OP_EXRT  = 6'h1B;

    typedef enum logic [3:0] {
        ALU_NOP = 4'd0, ALU_AND = 4'd1, ALU_OR = 4'd2, ALU_XOR = 4'd3, ALU_ADDS = 4'd4,
        ALU_ADDU = 4'd5, ALU_SUBS = 4'd6, ALU_SUBU = 4'd7, ALU_SHRL = 4'd8, ALU_SHLL = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {MEM_NOP = 2'd0, MEM_LDW = 2'd1, MEM_STW = 2'd2} mem_op_t;
    typedef enum logic [1:0] {CTRL_NOP = 2'd0, CTRL_WRCR = 2'd1, CTRL_EXRT = 2'd2} ctrl_op_t;

    typedef enum logic [2:0] {
        EXP_NO_EXP = 3'd0, EXP_EXT_INT = 3'd1, EXP_UNDEF_INSN = 3'd2, EXP_OVERFLOW = 3'd3,
        EXP_MISS_ALIGN = 3'd4, EXP_TRAP = 3'd5, EXP_PRV_VIO = 3'd6
    } exp_code_t;

    localparam logic MODE_KERNEL = 1'b0;
    localparam logic MODE_USER   = 1'b1;

    typedef struct packed {
        alu_op_t            alu_op;
        logic [WORD_W-1:0]  alu_in_0;
        logic [WORD_W-1:0]  alu_in_1;
        logic               br_flag;
        mem_op_t            mem_op;
        logic [WORD_W-1:0]  mem_wr_data;
        ctrl_op_t           ctrl_op;
        logic [REG_W-1:0]   dst_addr;
        logic               gpr_we_;
        exp_code_t          exp_code;
    } dec_t;

endpackage

// File: rtl/id_stage_if.sv
// ID/EX pipeline register bundle; ID drives it (master), EX consumes it (slave).
interface id_stage_if;
    import id_stage_pkg::*;

    logic [ADDR_W-1:0] id_pc;
    logic              id_en;
    logic [3:0]        id_alu_op;
    logic [WORD_W-1:0] id_alu_in_0;
    logic [WORD_W-1:0] id_alu_in_1;
    logic              id_br_flag;
    logic [1:0]        id_mem_op;
    logic [WORD_W-1:0] id_mem_wr_data;
    logic [1:0]        id_ctrl_op;
    logic [REG_W-1:0]  id_dst_addr;
    logic              id_gpr_we_;
    logic [2:0]        id_exp_code;

    modport master (output id_pc, id_en, id_alu_op, id_alu_in_0, id_alu_in_1, id_br_flag,
                    id_mem_op, id_mem_wr_data, id_ctrl_op, id_dst_addr, id_gpr_we_, id_exp_code);
    modport slave  (input  id_pc, id_en, id_alu_op, id_alu_in_0, id_alu_in_1, id_br_flag,
                    id_mem_op, id_mem_wr_data, id_ctrl_op, id_dst_addr, id_gpr_we_, id_exp_code);
endinterface

// File: rtl/id_stage_decoder.sv
// Combinational decode: operand forwarding, branch resolution and load-use hazard detection.
module id_stage_decoder
    import id_stage_pkg::*;
(
    input  logic [WORD_W-1:0] insn,
    input  logic [ADDR_W-1:0] pc,
    input  logic              en,
    input  logic [WORD_W-1:0] gpr_rd_data_0,
    input  logic [WORD_W-1:0] gpr_rd_data_1,
    input  logic              id_en,
    input  logic              id_gpr_we_,
    input  logic [REG_W-1:0]  id_dst_addr,
    input  logic [1:0]        id_mem_op,
    input  logic [WORD_W-1:0] ex_fwd_data,
    input  logic              ex_en,
    input  logic [REG_W-1:0]  ex_dst_addr,
    input  logic              ex_gpr_we_,
    input  logic [WORD_W-1:0] mem_fwd_data,
    input  logic              exe_mode,
    input  logic [WORD_W-1:0] creg_rd_data,
    output logic [REG_W-1:0]  gpr_rd_addr_0,
    output logic [REG_W-1:0]  gpr_rd_addr_1,
    output logic [REG_W-1:0]  creg_rd_addr,
    output logic [ADDR_W-1:0] br_addr,
    output logic              br_taken,
    output logic              ld_hazard,
    output dec_t              dec
);
    logic [5:0]        op;
    logic [REG_W-1:0]  ra, rb, rc;
    logic [WORD_W-1:0] imm_s, imm_u, ra_data, rb_data;
    logic [ADDR_W-1:0] br_target;

    assign op        = insn[31:26];
    assign ra        = insn[25:21];
    assign rb        = insn[20:16];
    assign rc        = insn[15:11];
    assign imm_s     = {{16{insn[15]}}, insn[15:0]};
    assign imm_u     = {16'h0000, insn[15:0]};
    assign br_target = pc + imm_s[ADDR_W-1:0];

    assign gpr_rd_addr_0 = ra;
    assign gpr_rd_addr_1 = rb;
    assign creg_rd_addr  = ra;

    // The instruction now in ID/EX is younger than the one in EX/MEM, so it wins.
    assign ra_data = (id_en && !id_gpr_we_ && id_dst_addr == ra) ? ex_fwd_data  :
                     (ex_en && !ex_gpr_we_ && ex_dst_addr == ra) ? mem_fwd_data : gpr_rd_data_0;
    assign rb_data = (id_en && !id_gpr_we_ && id_dst_addr == rb) ? ex_fwd_data  :
                     (ex_en && !ex_gpr_we_ && ex_dst_addr == rb) ? mem_fwd_data : gpr_rd_data_1;

    assign ld_hazard = id_en && (id_mem_op == MEM_LDW) && (id_dst_addr == ra || id_dst_addr == rb);

    always_comb begin
        dec          = '0;
        dec.alu_op   = ALU_NOP;
        dec.alu_in_0 = ra_data;
        dec.alu_in_1 = rb_data;
        dec.mem_op   = MEM_NOP;
        dec.ctrl_op  = CTRL_NOP;
        dec.dst_addr = rb;
        dec.gpr_we_  = 1'b1;
        dec.exp_code = EXP_NO_EXP;
        br_taken     = 1'b0;
        br_addr      = '0;
        if (en) begin
            case (op)
                OP_ANDR:  begin dec.alu_op = ALU_AND;  dec.dst_addr = rc; dec.gpr_we_ = 1'b0; end
                OP_ORR:   begin dec.alu_op = ALU_OR;   dec.dst_addr = rc; dec.gpr_we_ = 1'b0; end
                OP_XORR:  begin dec.alu_op = ALU_XOR;  dec.dst_addr = rc; dec.gpr_we_ = 1'b0; end
                OP_ADDSR: begin dec.alu_op = ALU_ADDS; dec.dst_addr = rc; dec.gpr_we_ = 1'b0; end
                OP_ADDUR: begin dec.alu_op = ALU_ADDU; dec.dst_addr = rc; dec.gpr_we_ = 1'b0; end
                OP_SUBSR: begin dec.alu_op = ALU_SUBS; dec.dst_addr = rc; dec.gpr_we_ = 1'b0; end
                OP_SUBUR: begin dec.alu_op = ALU_SUBU; dec.dst_addr = rc; dec.gpr_we_ = 1'b0; end
                OP_SHRLR: begin dec.alu_op = ALU_SHRL; dec.dst_addr = rc; dec.gpr_we_ = 1'b0; end
                OP_SHLLR: begin dec.alu_op = ALU_SHLL; dec.dst_addr = rc; dec.gpr_we_ = 1'b0; end
                OP_ANDI:  begin dec.alu_op = ALU_AND;  dec.alu_in_1 = imm_u; dec.gpr_we_ = 1'b0; end
                OP_ORI:   begin dec.alu_op = ALU_OR;   dec.alu_in_1 = imm_u; dec.gpr_we_ = 1'b0; end
                OP_XORI:  begin dec.alu_op = ALU_XOR;  dec.alu_in_1 = imm_u; dec.gpr_we_ = 1'b0; end
                OP_SHRLI: begin dec.alu_op = ALU_SHRL; dec.alu_in_1 = imm_u; dec.gpr_we_ = 1'b0; end
                OP_SHLLI: begin dec.alu_op = ALU_SHLL; dec.alu_in_1 = imm_u; dec.gpr_we_ = 1'b0; end
                OP_ADDSI: begin dec.alu_op = ALU_ADDS; dec.alu_in_1 = imm_s; dec.gpr_we_ = 1'b0; end
                OP_ADDUI: begin dec.alu_op = ALU_ADDU; dec.alu_in_1 = imm_s; dec.gpr_we_ = 1'b0; end
                OP_BE:    begin dec.br_flag = 1'b1; br_addr = br_target; br_taken = (ra_data == rb_data); end
                OP_BNE:   begin dec.br_flag = 1'b1; br_addr = br_target; br_taken = (ra_data != rb_data); end
                OP_BSGT:  begin
                    dec.br_flag = 1'b1; br_addr = br_target;
                    br_taken = ($signed(ra_data) < $signed(rb_data));
                end
                OP_BUGT:  begin dec.br_flag = 1'b1; br_addr = br_target; br_taken = (ra_data < rb_data); end
                OP_JMP:   begin dec.br_flag = 1'b1; br_addr = ra_data[31:2]; br_taken = 1'b1; end
                OP_CALL:  begin
                    dec.br_flag  = 1'b1; br_addr = ra_data[31:2]; br_taken = 1'b1;
                    dec.alu_in_0 = {pc, 2'b00};
                    dec.dst_addr = 5'd31;
                    dec.gpr_we_  = 1'b0;
                end
                OP_LDW:   begin
                    dec.alu_op = ALU_ADDU; dec.alu_in_1 = imm_s; dec.mem_op = MEM_LDW; dec.gpr_we_ = 1'b0;
                end
                OP_STW:   begin
                    dec.alu_op = ALU_ADDU; dec.alu_in_1 = imm_s; dec.mem_op = MEM_STW; dec.mem_wr_data = rb_data;
                end
                OP_TRAP:  dec.exp_code = EXP_TRAP;
                OP_RDCR:  begin
                    if (exe_mode == MODE_USER) dec.exp_code = EXP_PRV_VIO;
                    else begin dec.alu_in_0 = creg_rd_data; dec.dst_addr = rc; dec.gpr_we_ = 1'b0; end
                end
                OP_WRCR:  begin
                    if (exe_mode == MODE_USER) dec.exp_code = EXP_PRV_VIO;
                    else begin dec.ctrl_op = CTRL_WRCR; dec.alu_in_0 = ra_data; dec.dst_addr = rc; end
                end
                OP_EXRT:  begin
                    if (exe_mode == MODE_USER) dec.exp_code = EXP_PRV_VIO;
                    else dec.ctrl_op = CTRL_EXRT;
                end
                default:  dec.exp_code = EXP_UNDEF_INSN;
            endcase
        end
    end
endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: decoder plus the ID/EX pipeline register.
module id_stage
    import id_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] gpr_rd_data_0,
    input  logic [WORD_W-1:0] gpr_rd_data_1,
    output logic [REG_W-1:0]  gpr_rd_addr_0,
    output logic [REG_W-1:0]  gpr_rd_addr_1,
    input  logic              ex_en,
    input  logic [WORD_W-1:0] ex_fwd_data,
    input  logic [REG_W-1:0]  ex_dst_addr,
    input  logic              ex_gpr_we_,
    input  logic [WORD_W-1:0] mem_fwd_data,
    input  logic              exe_mode,
    input  logic [WORD_W-1:0] creg_rd_data,
    output logic [REG_W-1:0]  creg_rd_addr,
    input  logic              stall,
    input  logic              flush,
    output logic [ADDR_W-1:0] br_addr,
    output logic              br_taken,
    output logic              ld_hazard,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [WORD_W-1:0] if_insn,
    input  logic              if_en,
    id_stage_if.master        id_ex
);
    dec_t dec;

    id_stage_decoder u_decoder (
        .insn          (if_insn),
        .pc            (if_pc),
        .en            (if_en),
        .gpr_rd_data_0 (gpr_rd_data_0),
        .gpr_rd_data_1 (gpr_rd_data_1),
        .id_en         (id_ex.id_en),
        .id_gpr_we_    (id_ex.id_gpr_we_),
        .id_dst_addr   (id_ex.id_dst_addr),
        .id_mem_op     (id_ex.id_mem_op),
        .ex_fwd_data   (ex_fwd_data),
        .ex_en         (ex_en),
        .ex_dst_addr   (ex_dst_addr),
        .ex_gpr_we_    (ex_gpr_we_),
        .mem_fwd_data  (mem_fwd_data),
        .exe_mode      (exe_mode),
        .creg_rd_data  (creg_rd_data),
        .gpr_rd_addr_0 (gpr_rd_addr_0),
        .gpr_rd_addr_1 (gpr_rd_addr_1),
        .creg_rd_addr  (creg_rd_addr),
        .br_addr       (br_addr),
        .br_taken      (br_taken),
        .ld_hazard     (ld_hazard),
        .dec           (dec)
    );

    // Reset and flush both leave a bubble: everything zero, write enable deasserted.
    always_ff @(posedge clk) begin
        if (reset || (flush && !stall)) begin
            id_ex.id_pc          <= '0;
            id_ex.id_en          <= 1'b0;
            id_ex.id_alu_op      <= ALU_NOP;
            id_ex.id_alu_in_0    <= '0;
            id_ex.id_alu_in_1    <= '0;
            id_ex.id_br_flag     <= 1'b0;
            id_ex.id_mem_op      <= MEM_NOP;
            id_ex.id_mem_wr_data <= '0;
            id_ex.id_ctrl_op     <= CTRL_NOP;
            id_ex.id_dst_addr    <= '0;
            id_ex.id_gpr_we_     <= 1'b1;
            id_ex.id_exp_code    <= EXP_NO_EXP;
        end else if (!stall) begin
            id_ex.id_pc          <= if_pc;
            id_ex.id_en          <= if_en;
            id_ex.id_alu_op      <= dec.alu_op;
            id_ex.id_alu_in_0    <= dec.alu_in_0;
            id_ex.id_alu_in_1    <= dec.alu_in_1;
            id_ex.id_br_flag     <= dec.br_flag;
            id_ex.id_mem_op      <= dec.mem_op;
            id_ex.id_mem_wr_data <= dec.mem_wr_data;
            id_ex.id_ctrl_op     <= dec.ctrl_op;
            id_ex.id_dst_addr    <= dec.dst_addr;
            id_ex.id_gpr_we_     <= dec.gpr_we_;
            id_ex.id_exp_code    <= dec.exp_code;
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage with hand-computed expectations.
module tb_id_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] gpr_rd_data_0, gpr_rd_data_1;
    logic [4:0]  gpr_rd_addr_0, gpr_rd_addr_1;
    logic        ex_en;
    logic [31:0] ex_fwd_data;
    logic [4:0]  ex_dst_addr;
    logic        ex_gpr_we_;
    logic [31:0] mem_fwd_data;
    logic        exe_mode;
    logic [31:0] creg_rd_data;
    logic [4:0]  creg_rd_addr;
    logic        stall, flush;
    logic [29:0] br_addr;
    logic        br_taken, ld_hazard;
    logic [29:0] if_pc;
    logic [31:0] if_insn;
    logic        if_en;

    int checks = 0;
    int failures = 0;

    id_stage_if bus ();

    id_stage dut (
        .clk           (clk),
        .reset         (reset),
        .gpr_rd_data_0 (gpr_rd_data_0),
        .gpr_rd_data_1 (gpr_rd_data_1),
        .gpr_rd_addr_0 (gpr_rd_addr_0),
        .gpr_rd_addr_1 (gpr_rd_addr_1),
        .ex_en         (ex_en),
        .ex_fwd_data   (ex_fwd_data),
        .ex_dst_addr   (ex_dst_addr),
        .ex_gpr_we_    (ex_gpr_we_),
        .mem_fwd_data  (mem_fwd_data),
        .exe_mode      (exe_mode),
        .creg_rd_data  (creg_rd_data),
        .creg_rd_addr  (creg_rd_addr),
        .stall         (stall),
        .flush         (flush),
        .br_addr       (br_addr),
        .br_taken      (br_taken),
        .ld_hazard     (ld_hazard),
        .if_pc         (if_pc),
        .if_insn       (if_insn),
        .if_en         (if_en),
        .id_ex         (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; gpr_rd_data_0 = '0; gpr_rd_data_1 = '0; ex_en = 1'b0; ex_fwd_data = '0;
        ex_dst_addr = '0; ex_gpr_we_ = 1'b1; mem_fwd_data = '0; exe_mode = 1'b0; creg_rd_data = '0;
        stall = 1'b0; flush = 1'b0; if_pc = '0; if_insn = '0; if_en = 1'b0;
        tick(); tick();
        chk("rst_en", bus.id_en, 0);
        chk("rst_we", bus.id_gpr_we_, 1);
        chk("rst_pc", bus.id_pc, 0);
        chk("rst_alu_op", bus.id_alu_op, 0);
        chk("rst_in0", bus.id_alu_in_0, 0);
        chk("rst_dst", bus.id_dst_addr, 0);
        chk("rst_exp", bus.id_exp_code, 0);

        // ADDUI r4 = r3 + sext(0xFFFF)
        reset = 1'b0; if_en = 1'b1; if_pc = 30'd1000;
        if_insn = {6'h09, 5'd3, 5'd4, 16'hFFFF}; gpr_rd_data_0 = 32'd5; gpr_rd_data_1 = 32'd9;
        #1;
        chk("rd_addr0", gpr_rd_addr_0, 3);
        chk("rd_addr1", gpr_rd_addr_1, 4);
        tick();
        chk("addui_op", bus.id_alu_op, 5);
        chk("addui_in0", bus.id_alu_in_0, 5);
        chk("addui_in1", bus.id_alu_in_1, 32'hFFFF_FFFF);
        chk("addui_dst", bus.id_dst_addr, 4);
        chk("addui_we", bus.id_gpr_we_, 0);
        chk("addui_pc", bus.id_pc, 1000);
        chk("addui_en", bus.id_en, 1);

        // ADDSI r3 so ID/EX writes r3, then ADDUR r6 = r3 + r5 with EX/MEM also hitting r3
        if_insn = {6'h07, 5'd0, 5'd3, 16'h0001};
        tick();
        if_insn = {6'h08, 5'd3, 5'd5, 5'd6, 11'd0};
        ex_fwd_data = 32'd7; mem_fwd_data = 32'd8; ex_en = 1'b1; ex_dst_addr = 5'd3; ex_gpr_we_ = 1'b0;
        tick();
        chk("fwd_ex_wins", bus.id_alu_in_0, 7);
        chk("addur_dst", bus.id_dst_addr, 6);
        tick();
        chk("fwd_mem", bus.id_alu_in_0, 8);
        chk("fwd_none_rb", bus.id_alu_in_1, 9);
        ex_gpr_we_ = 1'b1;
        tick();
        chk("fwd_mem_we_off", bus.id_alu_in_0, 5);

        // Branches, combinational
        ex_en = 1'b0; if_insn = {6'h10, 5'd1, 5'd2, 16'd4}; gpr_rd_data_0 = 32'd42; gpr_rd_data_1 = 32'd42;
        #1;
        chk("be_taken", br_taken, 1);
        chk("be_addr", br_addr, 1004);
        gpr_rd_data_1 = 32'd43; #1;
        chk("be_not_taken", br_taken, 0);
        chk("be_addr_nt", br_addr, 1004);
        gpr_rd_data_1 = 32'd42; if_en = 1'b0; #1;
        chk("be_if_en0", br_taken, 0);
        chk("be_if_en0_addr", br_addr, 0);
        if_en = 1'b1; if_insn = {6'h10, 5'd1, 5'd2, 16'hFFFE}; #1;
        chk("be_neg_addr", br_addr, 998);
        if_insn = {6'h12, 5'd1, 5'd2, 16'd4}; gpr_rd_data_0 = 32'hFFFF_FFFF; gpr_rd_data_1 = 32'd1; #1;
        chk("bsgt_signed", br_taken, 1);
        if_insn = {6'h13, 5'd1, 5'd2, 16'd4}; #1;
        chk("bugt_unsigned", br_taken, 0);
        if_insn = {6'h14, 5'd1, 5'd2, 16'd0}; gpr_rd_data_0 = 32'h0000_1238; #1;
        chk("jmp_taken", br_taken, 1);
        chk("jmp_addr", br_addr, 30'h48E);
        if_insn = {6'h10, 5'd1, 5'd2, 16'd4}; gpr_rd_data_0 = 32'd42; gpr_rd_data_1 = 32'd42;
        tick();
        chk("be_br_flag", bus.id_br_flag, 1);
        chk("be_we", bus.id_gpr_we_, 1);
        chk("be_dst", bus.id_dst_addr, 2);

        // LDW r11 then load-use hazard probes
        if_insn = {6'h16, 5'd0, 5'd11, 16'd8}; gpr_rd_data_0 = 32'd100;
        tick();
        chk("ldw_mem", bus.id_mem_op, 1);
        chk("ldw_alu", bus.id_alu_op, 5);
        chk("ldw_in1", bus.id_alu_in_1, 8);
        chk("ldw_dst", bus.id_dst_addr, 11);
        chk("ldw_we", bus.id_gpr_we_, 0);
        if_insn = {6'h08, 5'd11, 5'd2, 5'd6, 11'd0}; #1;
        chk("haz_ra", ld_hazard, 1);
        if_insn = {6'h08, 5'd1, 5'd11, 5'd6, 11'd0}; #1;
        chk("haz_rb", ld_hazard, 1);
        if_insn = {6'h08, 5'd1, 5'd2, 5'd6, 11'd0}; #1;
        chk("haz_none", ld_hazard, 0);

        // STW, then stall/flush interaction
        if_insn = {6'h17, 5'd1, 5'd2, 16'hFFFC}; gpr_rd_data_1 = 32'h0000_DEAD;
        tick();
        chk("stw_mem", bus.id_mem_op, 2);
        chk("stw_wdata", bus.id_mem_wr_data, 32'h0000_DEAD);
        chk("stw_in1", bus.id_alu_in_1, 32'hFFFF_FFFC);
        chk("stw_we", bus.id_gpr_we_, 1);
        stall = 1'b1; if_insn = {6'h3F, 26'd0}; if_pc = 30'd77;
        for (int i = 0; i < 200; i++) begin
            tick();
            chk("stall_hold", {bus.id_mem_wr_data[15:0], 6'd0, bus.id_mem_op, bus.id_pc[7:0]},
                {16'hDEAD, 6'd0, 2'd2, 8'd232});
        end
        flush = 1'b1;
        tick();
        chk("stall_flush_hold_mem", bus.id_mem_op, 2);
        chk("stall_flush_hold_en", bus.id_en, 1);
        stall = 1'b0;
        tick();
        chk("flush_en", bus.id_en, 0);
        chk("flush_we", bus.id_gpr_we_, 1);
        chk("flush_mem", bus.id_mem_op, 0);
        chk("flush_wdata", bus.id_mem_wr_data, 0);
        chk("flush_pc", bus.id_pc, 0);
        chk("flush_exp", bus.id_exp_code, 0);
        chk("flush_in0", bus.id_alu_in_0, 0);

        // Privileged and exception decode
        flush = 1'b0; if_pc = 30'd1000; exe_mode = 1'b1; if_insn = {6'h19, 5'd2, 5'd3, 5'd7, 11'd0};
        tick();
        chk("rdcr_user_exp", bus.id_exp_code, 6);
        chk("rdcr_user_we", bus.id_gpr_we_, 1);
        exe_mode = 1'b0; creg_rd_data = 32'h0000_C0DE; #1;
        chk("creg_addr", creg_rd_addr, 2);
        tick();
        chk("rdcr_in0", bus.id_alu_in_0, 32'h0000_C0DE);
        chk("rdcr_dst", bus.id_dst_addr, 7);
        chk("rdcr_we", bus.id_gpr_we_, 0);
        chk("rdcr_exp", bus.id_exp_code, 0);
        if_insn = {6'h1A, 5'd2, 5'd3, 5'd7, 11'd0}; tick();
        chk("wrcr_ctrl", bus.id_ctrl_op, 1);
        if_insn = {6'h1B, 26'd0}; tick();
        chk("exrt_ctrl", bus.id_ctrl_op, 2);
        if_insn = {6'h18, 26'd0}; tick();
        chk("trap_exp", bus.id_exp_code, 5);
        if_insn = {6'h3F, 26'd0}; tick();
        chk("undef_exp", bus.id_exp_code, 2);
        if_insn = {6'h15, 5'd1, 5'd2, 16'd0}; gpr_rd_data_0 = 32'h0000_0040; #1;
        chk("call_taken", br_taken, 1);
        chk("call_addr", br_addr, 30'h10);
        tick();
        chk("call_in0", bus.id_alu_in_0, 32'd4000);
        chk("call_dst", bus.id_dst_addr, 31);
        chk("call_we", bus.id_gpr_we_, 0);
        if_en = 1'b0; tick();
        chk("if_en0_en", bus.id_en, 0);
        chk("if_en0_exp", bus.id_exp_code, 0);
        chk("if_en0_we", bus.id_gpr_we_, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
